// File: rtl/fatori_mon_pkg.sv
// rtl/fatori_mon_pkg.sv - shared types and helpers for the fatori monitor error sequencer
// Purpose: FSM state encoding and the counter-select width helper.
// Ports: none (package).
package fatori_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PENDING  = 3'd1,
    ST_RESYNC   = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FATAL    = 3'd4
  } err_seq_state_e;

  // Select width covering NSRC minority counters plus the two aggregates.
  function automatic int cnt_sel_w(input int nsrc);
    return $clog2(nsrc + 2);
  endfunction

endpackage

// File: rtl/fatori_sat_counter.sv
// rtl/fatori_sat_counter.sv - saturating event counter with synchronous clear
// Purpose: adds inc_i each cycle, sticking at all-ones; clr_i wins over increment.
// Ports:
//   clk_i  in  1   clock
//   rst_ni in  1   asynchronous active-low reset
//   clr_i  in  1   synchronous clear
//   inc_i  in  IW  increment amount
//   cnt_o  out W   counter value
module fatori_sat_counter #(
  parameter int W  = 16,
  parameter int IW = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic [IW-1:0] inc_i,
  output logic [W-1:0]  cnt_o
);

  // One extra bit beyond the wider operand so the overflow is observable.
  localparam int SW = ((W > IW) ? W : IW) + 1;
  localparam logic [SW-1:0] MAXV = SW'({W{1'b1}});

  logic [SW-1:0] sum;
  assign sum = SW'(cnt_o) + SW'(inc_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (sum > MAXV) begin
      cnt_o <= '1;
    end else begin
      cnt_o <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/fatori_mon_err_sequencer.sv
// rtl/fatori_mon_err_sequencer.sv - recovery scheduler for fatori M-of-N monitor wrappers
// Purpose: edge-detects min/maj/scrub status from NSRC voted wrappers, counts the
// events, and schedules a resync handshake once the core is idle. Majority loss
// (MAJ_FATAL=1) escalates to a sticky FATAL state that halts the core.
// Optional feature macro: FATORI_MON_TIMEOUT_EN enables a RESYNC ack watchdog
// that goes to FATAL after TIMEOUT cycles without resync_ack_i.
// Ports:
//   clk_i         in  1      clock, rising edge
//   rst_ni        in  1      asynchronous active-low reset
//   min_err_i     in  NSRC   minority-disagreement levels
//   maj_err_i     in  NSRC   no-majority levels
//   scrub_i       in  NSRC   scrub_occurred levels
//   core_idle_i   in  1      core has nothing in flight
//   resync_req_o  out 1      resync request (state RESYNC)
//   resync_ack_i  in  1      resync done
//   halt_o        out 1      core halt (state FATAL)
//   irq_o         out 1      completion pulse, or constant high in FATAL
//   clr_i         in  1      clear all counters
//   cnt_sel_i     in  SELW   counter read select
//   cnt_o         out CNT_W  selected counter
//   state_o       out 3      FSM state
//   src_mask_o    out NSRC   wrappers pending or under resync
module fatori_mon_err_sequencer
  import fatori_mon_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 64,
  parameter int COOLDOWN  = 8,
  parameter int MAJ_FATAL = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NSRC-1:0]              min_err_i,
  input  logic [NSRC-1:0]              maj_err_i,
  input  logic [NSRC-1:0]              scrub_i,
  input  logic                         core_idle_i,
  output logic                         resync_req_o,
  input  logic                         resync_ack_i,
  output logic                         halt_o,
  output logic                         irq_o,
  input  logic                         clr_i,
  input  logic [cnt_sel_w(NSRC)-1:0]   cnt_sel_i,
  output logic [CNT_W-1:0]             cnt_o,
  output logic [2:0]                   state_o,
  output logic [NSRC-1:0]              src_mask_o
);

  localparam int SELW = cnt_sel_w(NSRC);
  localparam int PW   = $clog2(NSRC + 1);
  localparam int CDW  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  // Two-stage edge detect: stage 1 is the sampled level, stage 2 its previous value.
  logic [NSRC-1:0] min_r1, min_r2, maj_r1, maj_r2, scrub_r1, scrub_r2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_r1   <= '0;
      min_r2   <= '0;
      maj_r1   <= '0;
      maj_r2   <= '0;
      scrub_r1 <= '0;
      scrub_r2 <= '0;
    end else begin
      min_r1   <= min_err_i;
      min_r2   <= min_r1;
      maj_r1   <= maj_err_i;
      maj_r2   <= maj_r1;
      scrub_r1 <= scrub_i;
      scrub_r2 <= scrub_r1;
    end
  end

  logic [NSRC-1:0] min_ev, maj_ev, scrub_ev, ev_mask;
  logic            maj_hit;
  logic [PW-1:0]   scrub_pop;

  assign min_ev   = min_r1 & ~min_r2;
  assign maj_ev   = maj_r1 & ~maj_r2;
  assign scrub_ev = scrub_r1 & ~scrub_r2;

  // Without fatal escalation a majority loss is scheduled like a minority one.
  assign ev_mask = min_ev | ((MAJ_FATAL != 0) ? '0 : maj_ev);
  assign maj_hit = (MAJ_FATAL != 0) && (|maj_ev);

  always_comb begin
    scrub_pop = '0;
    for (int s = 0; s < NSRC; s++) begin
      scrub_pop = scrub_pop + PW'(scrub_ev[s]);
    end
  end

  logic [CNT_W-1:0] min_cnt [NSRC];
  logic [CNT_W-1:0] maj_cnt, scrub_cnt;

  for (genvar s = 0; s < NSRC; s++) begin : g_min
    fatori_sat_counter #(.W(CNT_W), .IW(1)) u_min_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .inc_i  (min_ev[s]),
      .cnt_o  (min_cnt[s])
    );
  end

  fatori_sat_counter #(.W(CNT_W), .IW(1)) u_maj_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (|maj_ev),
    .cnt_o  (maj_cnt)
  );

  fatori_sat_counter #(.W(CNT_W), .IW(PW)) u_scrub_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (scrub_pop),
    .cnt_o  (scrub_cnt)
  );

  always_comb begin
    cnt_o = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (cnt_sel_i == SELW'(s)) cnt_o = min_cnt[s];
    end
    if (cnt_sel_i == SELW'(NSRC))     cnt_o = maj_cnt;
    if (cnt_sel_i == SELW'(NSRC + 1)) cnt_o = scrub_cnt;
  end

  err_seq_state_e  state;
  logic [NSRC-1:0] mask;
  logic            irq;
  logic [CDW-1:0]  cool_cnt;
`ifdef FATORI_MON_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0]  wd_cnt;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      mask     <= '0;
      irq      <= 1'b0;
      cool_cnt <= '0;
`ifdef FATORI_MON_TIMEOUT_EN
      wd_cnt   <= '0;
`endif
    end else begin
      irq <= 1'b0;
      // FATAL is sticky and a majority hit overrides every other transition.
      if (maj_hit || state == ST_FATAL) begin
        state <= ST_FATAL;
        irq   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (|ev_mask) begin
              state <= ST_PENDING;
              mask  <= mask | ev_mask;
            end
          end
          ST_PENDING: begin
            mask <= mask | ev_mask;
            if (core_idle_i) begin
              state <= ST_RESYNC;
`ifdef FATORI_MON_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end
          end
          ST_RESYNC: begin
            if (resync_ack_i) begin
              // Only sources flagged before the ack are considered resynced.
              state    <= ST_COOLDOWN;
              mask     <= ev_mask;
              irq      <= 1'b1;
              cool_cnt <= '0;
            end else begin
              mask <= mask | ev_mask;
`ifdef FATORI_MON_TIMEOUT_EN
              if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                state <= ST_FATAL;
                irq   <= 1'b1;
              end else begin
                wd_cnt <= wd_cnt + 1'b1;
              end
`endif
            end
          end
          ST_COOLDOWN: begin
            mask <= mask | ev_mask;
            if (cool_cnt == CDW'(COOLDOWN - 1)) begin
              cool_cnt <= '0;
              state    <= (|(mask | ev_mask)) ? ST_PENDING : ST_IDLE;
            end else begin
              cool_cnt <= cool_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_o      = state;
  assign resync_req_o = (state == ST_RESYNC);
  assign halt_o       = (state == ST_FATAL);
  assign irq_o        = irq;
  assign src_mask_o   = mask;

endmodule

// File: tb/tb_fatori_mon_err_sequencer.sv
// tb/tb_fatori_mon_err_sequencer.sv - scoreboard bench for fatori_mon_err_sequencer
module tb_fatori_mon_err_sequencer;

  localparam int NSRC     = 4;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 64;
  localparam int COOLDOWN = 8;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] min_err, maj_err, scrub;
  logic       core_idle, ack, clr;
  logic [2:0] sel;
  logic       resync_req, halt, irq;
  logic [3:0] cnt, mask;
  logic [2:0] state;

  fatori_mon_err_sequencer #(
    .NSRC(NSRC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN), .MAJ_FATAL(1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .min_err_i    (min_err),
    .maj_err_i    (maj_err),
    .scrub_i      (scrub),
    .core_idle_i  (core_idle),
    .resync_req_o (resync_req),
    .resync_ack_i (ack),
    .halt_o       (halt),
    .irq_o        (irq),
    .clr_i        (clr),
    .cnt_sel_i    (sel),
    .cnt_o        (cnt),
    .state_o      (state),
    .src_mask_o   (mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    int mask;
    int req;
    int halt;
    int irq;
    int cnt;
  } exp_t;
  exp_t sb[$];

  // Reference model: 0 idle, 1 pending, 2 resync, 3 cooldown, 4 fatal.
  int m_st, m_mask, m_irq, m_maj, m_scr, m_wd, m_cool_left;
  int m_min [NSRC];
  int h_min_cur, h_min_prev, h_maj_cur, h_maj_prev, h_scr_cur, h_scr_prev;

  function void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function int sat_add(int a, int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  function void model_reset();
    m_st = 0; m_mask = 0; m_irq = 0; m_maj = 0; m_scr = 0; m_wd = 0; m_cool_left = 0;
    for (int s = 0; s < NSRC; s++) m_min[s] = 0;
    h_min_cur = 0; h_min_prev = 0; h_maj_cur = 0; h_maj_prev = 0; h_scr_cur = 0; h_scr_prev = 0;
  endfunction

  // One rising edge: events come from the inputs seen at the two previous edges.
  function void model_step();
    int evn, evj, evs;
    bit pulse;
    evn = h_min_cur & ~h_min_prev & 15;
    evj = h_maj_cur & ~h_maj_prev & 15;
    evs = h_scr_cur & ~h_scr_prev & 15;
    if (clr) begin
      for (int s = 0; s < NSRC; s++) m_min[s] = 0;
      m_maj = 0;
      m_scr = 0;
    end else begin
      for (int s = 0; s < NSRC; s++) m_min[s] = sat_add(m_min[s], (evn >> s) & 1);
      m_maj = sat_add(m_maj, (evj != 0) ? 1 : 0);
      m_scr = sat_add(m_scr, $countones(evs));
    end
    pulse = 0;
    if (evj != 0 || m_st == 4) begin
      m_st = 4;
    end else if (m_st == 0) begin
      if (evn != 0) begin m_st = 1; m_mask = evn; end
    end else if (m_st == 1) begin
      m_mask |= evn;
      if (core_idle) begin m_st = 2; m_wd = 0; end
    end else if (m_st == 2) begin
      if (ack) begin
        m_st = 3; m_mask = evn; pulse = 1; m_cool_left = COOLDOWN;
      end else begin
        m_mask |= evn;
`ifdef FATORI_MON_TIMEOUT_EN
        m_wd++;
        if (m_wd == TIMEOUT) m_st = 4;
`endif
      end
    end else begin
      m_mask |= evn;
      m_cool_left--;
      if (m_cool_left == 0) m_st = (m_mask != 0) ? 1 : 0;
    end
    m_irq = (m_st == 4 || pulse) ? 1 : 0;
    h_min_prev = h_min_cur; h_min_cur = int'(min_err);
    h_maj_prev = h_maj_cur; h_maj_cur = int'(maj_err);
    h_scr_prev = h_scr_cur; h_scr_cur = int'(scrub);
  endfunction

  function void push_exp();
    exp_t e;
    e.st   = m_st;
    e.mask = m_mask;
    e.req  = (m_st == 2) ? 1 : 0;
    e.halt = (m_st == 4) ? 1 : 0;
    e.irq  = m_irq;
    if (int'(sel) < NSRC)       e.cnt = m_min[sel];
    else if (int'(sel) == NSRC) e.cnt = m_maj;
    else if (int'(sel) == NSRC + 1) e.cnt = m_scr;
    else e.cnt = 0;
    sb.push_back(e);
  endfunction

  task automatic next(input int mn, input int mj, input int sc, input int idl,
                      input int ak, input int cl, input int rs, input int sl);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    min_err   = 4'(mn);
    maj_err   = 4'(mj);
    scrub     = 4'(sc);
    core_idle = (idl != 0);
    ack       = (ak != 0);
    clr       = (cl != 0);
    rst_n     = (rs != 0);
    sel       = 3'(sl);
    if (!rst_n) model_reset();
    push_exp();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", int'(state), e.st);
      chk("src_mask", int'(mask), e.mask);
      chk("resync_req", int'(resync_req), e.req);
      chk("halt", int'(halt), e.halt);
      chk("irq", int'(irq), e.irq);
      chk("cnt", int'(cnt), e.cnt);
    end
  end

  initial begin
    int mn, mj, sc, rs, fatal_cycles;
    rst_n = 1'b0; min_err = '0; maj_err = '0; scrub = '0;
    core_idle = 1'b0; ack = 1'b0; clr = 1'b0; sel = '0;
    model_reset();
    next(0, 0, 0, 0, 0, 0, 0, 0);
    next(0, 0, 0, 0, 0, 0, 0, 0);
    next(0, 0, 0, 1, 0, 0, 1, 2);

    // Minority path on source 2 with ack at the sixth cycle.
    for (int i = 0; i < 20; i++) next(4, 0, 0, 1, (i == 5) ? 1 : 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) next(0, 0, 0, 1, 0, 0, 1, 2);

    // Idle gating on source 0.
    for (int i = 0; i < 12; i++) next(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) next(1, 0, 0, 1, (i == 3) ? 1 : 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) next(0, 0, 0, 1, 0, 0, 1, 0);

    // Saturation of min_cnt[3], then clear racing a new event.
    for (int i = 0; i < 40; i++) next((i % 2) ? 8 : 0, 0, 0, 1, 1, 0, 1, 3);
    next(0, 0, 0, 1, 1, 0, 1, 3);
    next(8, 0, 0, 1, 1, 1, 1, 3);
    next(8, 0, 0, 1, 1, 1, 1, 3);
    for (int i = 0; i < 12; i++) next(0, 0, 0, 1, 1, 0, 1, 3);

    // Simultaneous scrub rising on all sources, then held.
    for (int i = 0; i < 6; i++) next(0, 0, 15, 1, 0, 0, 1, 5);
    next(0, 0, 0, 1, 0, 0, 1, 5);

    // Majority loss during RESYNC; clear does not leave FATAL; reset does.
    for (int i = 0; i < 4; i++) next(2, 0, 0, 1, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) next(2, 2, 0, 1, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) next(2, 2, 0, 1, 1, 1, 1, 4);
    next(0, 0, 0, 0, 0, 0, 0, 4);
    next(0, 0, 0, 0, 0, 0, 0, 4);
    next(0, 0, 0, 1, 0, 0, 1, 4);

    // No ack: watchdog (if built) or indefinite wait in RESYNC.
    for (int i = 0; i < 200; i++) next(1, 0, 0, 1, 0, 0, 1, 0);
    next(0, 0, 0, 0, 0, 0, 0, 0);
    next(0, 0, 0, 1, 0, 0, 1, 0);

    // Randomized traffic.
    mn = 0; mj = 0; sc = 0; fatal_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom % 8 == 0) mn ^= (1 << b);
        if ($urandom % 4 == 0) sc ^= (1 << b);
      end
      if ($urandom % 250 == 0) mj ^= (1 << ($urandom % 4));
      fatal_cycles = (m_st == 4) ? fatal_cycles + 1 : 0;
      rs = ($urandom % 200 == 0 || fatal_cycles > 15) ? 0 : 1;
      if (rs == 0) mj = 0;
      next(mn, mj, sc, ($urandom % 3 != 0) ? 1 : 0, ($urandom % 4 == 0) ? 1 : 0,
           ($urandom % 60 == 0) ? 1 : 0, rs, $urandom % 8);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
